// File: rtl/pif_fade_ctrl.sv
// Pattern generator for the PWM LED flasher: divides Clk down to a Tick and steps
// Duty/Phase per the host-selected mode; commands take effect on a Tick boundary.
module pif_fade_ctrl #(
   parameter int TICK_DIV = 177333,
   parameter int CW       = 18,
   parameter int B        = 5
) (
   input  logic         Clk,
   input  logic         ResetN,
   input  logic         CmdValid,
   output logic         CmdReady,
   input  logic [1:0]   CmdMode,
   input  logic [3:0]   CmdRate,
   output logic         Tick,
   output logic [B-1:0] Duty,
   output logic [1:0]   Phase,
   output logic         Busy
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_SOLID   = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_CYCLE   = 2'd3
   } mode_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);
   localparam logic [B-1:0]  DMAX   = '1;

   state_t        state, state_nxt;
   mode_t         mode, pend_mode;
   logic [CW-1:0] presc;
   logic [3:0]    rate, pend_rate, step_cnt;
   logic          dir_dn;
   logic          accept, apply, step_fire;
   logic [B+2:0]  pattern_nxt;

   // Returns {dir_dn, Phase, Duty} after one step in mode m.
   function automatic logic [B+2:0] next_pattern(
      input mode_t        m,
      input logic         dn,
      input logic [1:0]   ph,
      input logic [B-1:0] d
   );
      logic [B+1:0] cyc;
      cyc          = {ph, d} + 1'b1;
      next_pattern = '0;
      case (m)
         MODE_SOLID:   next_pattern = {1'b0, 2'b00, DMAX};
         MODE_BREATHE: begin
            if (!dn)
               next_pattern = (d == DMAX) ? {1'b1, ph, d} : {1'b0, ph, d + 1'b1};
            else
               next_pattern = (d == '0) ? {1'b0, ph + 2'd1, d} : {1'b1, ph, d - 1'b1};
         end
         MODE_CYCLE:   next_pattern = {dn, cyc};
         default:      next_pattern = '0;
      endcase
   endfunction

   assign CmdReady = (state == ST_RUN);
   assign Busy     = (state == ST_PEND);

   always_comb begin
      accept      = CmdValid && (state == ST_RUN);
      apply       = Tick && (state == ST_PEND);
      step_fire   = Tick && !apply && (step_cnt == rate);
      pattern_nxt = next_pattern(mode, dir_dn, Phase, Duty);
      state_nxt   = state;
      case (state)
         ST_RUN:  if (accept) state_nxt = ST_PEND;
         ST_PEND: if (Tick)   state_nxt = ST_RUN;
         default: state_nxt = ST_RUN;
      endcase
   end

   // Pending command holding registers; only meaningful while in ST_PEND.
   always_ff @(posedge Clk) begin
      if (accept) begin
         pend_mode <= mode_t'(CmdMode);
         pend_rate <= CmdRate;
      end
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         presc    <= RELOAD;
         Tick     <= 1'b0;
         state    <= ST_RUN;
         mode     <= MODE_OFF;
         rate     <= '0;
         step_cnt <= '0;
         dir_dn   <= 1'b0;
         Duty     <= '0;
         Phase    <= '0;
      end else begin
         Tick  <= (presc == '0);
         presc <= (presc == '0) ? RELOAD : presc - 1'b1;
         state <= state_nxt;
         if (apply) begin
            mode     <= pend_mode;
            rate     <= pend_rate;
            step_cnt <= '0;
            dir_dn   <= 1'b0;
            Phase    <= '0;
            Duty     <= (pend_mode == MODE_SOLID) ? DMAX : '0;
         end else if (Tick) begin
            if (step_fire) begin
               step_cnt                <= '0;
               {dir_dn, Phase, Duty}   <= pattern_nxt;
            end else begin
               step_cnt <= step_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pif_fade_ctrl.sv
// Self-checking bench for pif_fade_ctrl with a small TICK_DIV and a closed-form
// reference model of the Duty/Phase patterns.
module tb_pif_fade_ctrl;

   localparam int TD  = 8;
   localparam int CWT = 4;
   localparam int BT  = 5;

   logic          Clk      = 1'b0;
   logic          ResetN   = 1'b0;
   logic          CmdValid = 1'b0;
   logic [1:0]    CmdMode  = 2'd0;
   logic [3:0]    CmdRate  = 4'd0;
   logic          CmdReady;
   logic          Tick;
   logic [BT-1:0] Duty;
   logic [1:0]    Phase;
   logic          Busy;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycles since release, pending command, active
   // command and number of steps taken since the last apply.
   int m_cyc;
   bit m_tick;
   bit m_pend;
   int m_mode, m_rate, m_pmode, m_prate, m_tcnt, m_s;

   always #5 Clk = ~Clk;

   pif_fade_ctrl #(.TICK_DIV(TD), .CW(CWT), .B(BT)) dut (
      .Clk      (Clk),
      .ResetN   (ResetN),
      .CmdValid (CmdValid),
      .CmdReady (CmdReady),
      .CmdMode  (CmdMode),
      .CmdRate  (CmdRate),
      .Tick     (Tick),
      .Duty     (Duty),
      .Phase    (Phase),
      .Busy     (Busy)
   );

   function automatic logic [4:0] exp_duty();
      int t;
      case (m_mode)
         1: return 5'd31;
         2: begin
            t = m_s % 64;
            return (t < 32) ? 5'(t) : 5'(63 - t);
         end
         3: return 5'(m_s % 32);
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic [1:0] exp_phase();
      case (m_mode)
         2: return 2'((m_s / 64) % 4);
         3: return 2'((m_s / 32) % 4);
         default: return 2'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_tick = 0; m_pend = 0;
      m_mode = 0; m_rate = 0; m_pmode = 0; m_prate = 0;
      m_tcnt = 0; m_s = 0;
   endtask

   // One clock: advance the model across the edge, return at the next negedge.
   task automatic step();
      bit acc;
      @(posedge Clk);
      acc = CmdValid && !m_pend;
      if (m_tick && m_pend) begin
         m_mode = m_pmode; m_rate = m_prate; m_s = 0; m_tcnt = 0; m_pend = 0;
      end else if (m_tick) begin
         if (m_tcnt == m_rate) begin
            m_tcnt = 0;
            m_s++;
         end else begin
            m_tcnt++;
         end
      end
      if (acc) begin
         m_pend  = 1;
         m_pmode = int'(CmdMode);
         m_prate = int'(CmdRate);
      end
      m_cyc++;
      m_tick = ((m_cyc % TD) == 0);
      @(negedge Clk);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      ResetN   = 1'b0;
      CmdValid = 1'b0;
      repeat (2) @(negedge Clk);
      ResetN = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      @(negedge Clk);
      checks++; if (Duty !== 5'd0) begin errors++; $display("FAIL reset_duty got %0d want 0", Duty); end
      checks++; if (Phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", Phase); end
      checks++; if (Tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %0b want 0", Tick); end
      checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", CmdReady); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", Busy); end
      ResetN = 1'b1;
      model_reset();
      for (int k = 1; k <= 3 * TD; k++) begin
         step();
         checks++; if (Tick !== ((k % TD) == 0)) begin errors++; $display("FAIL tick_period cycle %0d got %0b want %0b", k, Tick, (k % TD) == 0); end
         checks++; if (Duty !== 5'd0 || Phase !== 2'd0) begin errors++; $display("FAIL idle_out cycle %0d got duty %0d phase %0d want 0 0", k, Duty, Phase); end
         checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL idle_ready cycle %0d got %0b want 1", k, CmdReady); end
      end
   endtask

   task automatic test_solid();
      do_reset();
      repeat (3) step();
      CmdValid = 1'b1; CmdMode = 2'd1; CmdRate = 4'd0;
      step();
      CmdValid = 1'b0;
      for (int k = 4; k <= 8; k++) begin
         checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL solid_busy cycle %0d got %0b want 1", k, Busy); end
         checks++; if (CmdReady !== 1'b0) begin errors++; $display("FAIL solid_ready cycle %0d got %0b want 0", k, CmdReady); end
         checks++; if (Duty !== 5'd0) begin errors++; $display("FAIL solid_early cycle %0d got %0d want 0", k, Duty); end
         if (k < 8) step();
      end
      checks++; if (Tick !== 1'b1) begin errors++; $display("FAIL solid_tick8 got %0b want 1", Tick); end
      step();
      checks++; if (Duty !== 5'd31) begin errors++; $display("FAIL solid_duty got %0d want 31", Duty); end
      checks++; if (CmdReady !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL solid_done got ready %0b busy %0b want 1 0", CmdReady, Busy); end
      repeat (2 * TD) begin
         step();
         checks++; if (Duty !== exp_duty() || Phase !== exp_phase()) begin errors++; $display("FAIL solid_hold got %0d/%0d want %0d/%0d", Duty, Phase, exp_duty(), exp_phase()); end
      end
   endtask

   task automatic test_tick_accept();
      for (int i = 0; i <= TD && !m_tick; i++) step();
      checks++; if (Tick !== 1'b1) begin errors++; $display("FAIL ta_align got %0b want 1", Tick); end
      CmdValid = 1'b1; CmdMode = 2'd3; CmdRate = 4'd0;
      step();
      CmdValid = 1'b0;
      for (int i = 1; i <= TD; i++) begin
         checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL ta_busy offset %0d got %0b want 1", i, Busy); end
         checks++; if (Duty !== 5'd31) begin errors++; $display("FAIL ta_not_applied offset %0d got %0d want 31", i, Duty); end
         checks++; if (Tick !== m_tick) begin errors++; $display("FAIL ta_tick offset %0d got %0b want %0b", i, Tick, m_tick); end
         step();
      end
      checks++; if (Busy !== 1'b0 || Duty !== 5'd0 || Phase !== 2'd0) begin errors++; $display("FAIL ta_applied got busy %0b duty %0d phase %0d want 0 0 0", Busy, Duty, Phase); end
   endtask

   task automatic test_breathe();
      bit         saw_wrap = 0;
      logic [1:0] prev_ph  = 2'd0;
      CmdValid = 1'b1; CmdMode = 2'd2; CmdRate = 4'd0;
      step();
      CmdValid = 1'b0;
      repeat (260 * TD) begin
         step();
         checks++; if (Duty !== exp_duty()) begin errors++; $display("FAIL breathe_duty step %0d got %0d want %0d", m_s, Duty, exp_duty()); end
         checks++; if (Phase !== exp_phase()) begin errors++; $display("FAIL breathe_phase step %0d got %0d want %0d", m_s, Phase, exp_phase()); end
         checks++; if (Busy !== m_pend || Tick !== m_tick) begin errors++; $display("FAIL breathe_ctl got busy %0b tick %0b want %0b %0b", Busy, Tick, m_pend, m_tick); end
         if (prev_ph == 2'd3 && Phase == 2'd0) saw_wrap = 1;
         prev_ph = Phase;
      end
      checks++; if (saw_wrap !== 1'b1) begin errors++; $display("FAIL breathe_wrap got %0b want 1", saw_wrap); end
   endtask

   task automatic test_cycle();
      bit         saw_wrap = 0;
      logic [6:0] prev_v   = 7'd0;
      CmdValid = 1'b1; CmdMode = 2'd3; CmdRate = 4'd2;
      step();
      CmdValid = 1'b0;
      repeat (2 * TD + 130 * 3 * TD) begin
         step();
         checks++; if ({Phase, Duty} !== {exp_phase(), exp_duty()}) begin errors++; $display("FAIL cycle_value step %0d got %0d want %0d", m_s, {Phase, Duty}, {exp_phase(), exp_duty()}); end
         if (prev_v == 7'd127 && {Phase, Duty} == 7'd0) saw_wrap = 1;
         prev_v = {Phase, Duty};
      end
      checks++; if (saw_wrap !== 1'b1) begin errors++; $display("FAIL cycle_wrap got %0b want 1", saw_wrap); end
   endtask

   task automatic test_random();
      repeat (3000) begin
         CmdValid = ($urandom_range(0, 19) == 0);
         CmdMode  = 2'($urandom_range(0, 3));
         CmdRate  = 4'($urandom_range(0, 3));
         step();
         checks++; if (Tick !== m_tick) begin errors++; $display("FAIL rand_tick cycle %0d got %0b want %0b", m_cyc, Tick, m_tick); end
         checks++; if (Duty !== exp_duty()) begin errors++; $display("FAIL rand_duty cycle %0d got %0d want %0d", m_cyc, Duty, exp_duty()); end
         checks++; if (Phase !== exp_phase()) begin errors++; $display("FAIL rand_phase cycle %0d got %0d want %0d", m_cyc, Phase, exp_phase()); end
         checks++; if (Busy !== m_pend || CmdReady !== !m_pend) begin errors++; $display("FAIL rand_hs cycle %0d got busy %0b ready %0b want %0b %0b", m_cyc, Busy, CmdReady, m_pend, !m_pend); end
      end
      CmdValid = 1'b0;
   endtask

   task automatic test_reset_pend();
      do_reset();
      repeat (2) step();
      CmdValid = 1'b1; CmdMode = 2'd1; CmdRate = 4'd0;
      repeat (3) step();
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rp_pending got %0b want 1", Busy); end
      #2 ResetN = 1'b0;
      #1;
      checks++; if (Busy !== 1'b0 || CmdReady !== 1'b1) begin errors++; $display("FAIL rp_async_hs got busy %0b ready %0b want 0 1", Busy, CmdReady); end
      checks++; if (Duty !== 5'd0 || Phase !== 2'd0 || Tick !== 1'b0) begin errors++; $display("FAIL rp_async_out got %0d/%0d/%0b want 0/0/0", Duty, Phase, Tick); end
      CmdMode = 2'd2;
      repeat (2) @(negedge Clk);
      ResetN = 1'b1;
      model_reset();
      step();
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rp_reaccept got %0b want 1", Busy); end
      repeat (TD) begin
         step();
         checks++; if (Duty !== 5'd0) begin errors++; $display("FAIL rp_discard cycle %0d got %0d want 0", m_cyc, Duty); end
      end
      checks++; if (Busy !== 1'b0 || CmdReady !== 1'b1) begin errors++; $display("FAIL rp_applied got busy %0b ready %0b want 0 1", Busy, CmdReady); end
      CmdValid = 1'b0;
      repeat (4 * TD) begin
         step();
         checks++; if (Duty !== exp_duty() || Phase !== exp_phase()) begin errors++; $display("FAIL rp_breathe cycle %0d got %0d/%0d want %0d/%0d", m_cyc, Duty, Phase, exp_duty(), exp_phase()); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_solid();
      test_tick_accept();
      test_breathe();
      test_cycle();
      test_random();
      test_reset_pend();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
